ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port irom_adr  output  32  fetch address to the instruction ROM, equal to the current PC register.
REQ-005 SHALL have port irom_inst  input  32  instruction word from the ROM, combinational response to irom_adr in the same cycle.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request from execute.
REQ-007 SHALL have port redirect_pc  input  32  redirect target address.
REQ-008 SHALL have port if_valid  output  1  fetch-buffer head holds a valid instruction for decode.
REQ-009 SHALL have port if_pc  output  32  PC of the head instruction.
REQ-010 SHALL have port if_inst  output  32  head instruction word.
REQ-011 SHALL have port if_ready  input  1  decode accepts the head this cycle.

Function
REQ-012 SHALL hold a 32-bit PC register and a 2-entry FIFO of {pc, inst} pairs with a 2-bit occupancy count (0..2).
REQ-013 SHALL define pop = if_valid & if_ready; push = ~redirect_valid & (count<2 | pop).
REQ-014 SHALL, on push, write {PC, irom_inst} at the FIFO tail and set PC <= PC+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-015 SHALL, when FIFO full and no pop, hold PC and FIFO unchanged (irom_adr stable).
REQ-016 SHALL support simultaneous push and pop at any count, count unchanged; at count 0 the pushed entry becomes head next cycle (no bypass; fetch-to-if_valid latency 1 cycle).
REQ-017 SHALL drive if_valid = (count!=0) & ~redirect_valid; if_pc/if_inst from head entry, don't-care when if_valid=0.
REQ-018 SHALL, when redirect_valid=1, flush FIFO (count <= 0), set PC <= {redirect_pc[31:2],2'b00}, suppress push and pop; redirect has priority over every other event.
REQ-019 SHALL, after a redirect, present the target instruction with if_valid=1 exactly 2 cycles after the redirect cycle (cycle+1 fetch, cycle+2 head).
REQ-020 SHALL keep head pointer and tail pointer as 1-bit indices toggling on pop and push respectively.

Reset
REQ-021 SHALL, when rst_n=0 at a rising edge, set PC <= RESET_PC, count <= 0, pointers <= 0; if_valid=0 during and one cycle after reset.
REQ-022 SHALL let reset override redirect_valid, push and pop in the same cycle, including mid-stall with a full FIFO.
REQ-023 SHALL perform first push on the first rising edge with rst_n=1.

Configuration
REQ-024 SHALL, with macro IFETCH_PERF_EN defined, add outputs perf_fetch_cnt (32) counting pops and perf_redirect_cnt (32) counting redirect cycles, both cleared on reset, wrapping at 2^32.
REQ-025 SHALL, without IFETCH_PERF_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-026 SHALL cover: reset release, if_ready=1 held, ROM word[i]=i -> if_valid=1 from cycle 1, if_pc=0,4,8,... and if_inst=0,1,2,... one per cycle.
REQ-027 SHALL cover: if_ready=0 for 5 cycles from cycle 3 -> count reaches 2, irom_adr frozen at 0x10, resume yields if_pc=0x8,0xC,0x10 with no loss or duplicate.
REQ-028 SHALL cover: redirect_valid=1, redirect_pc=0x0000_0103 while full -> if_valid=0 that cycle and next, irom_adr=0x100 next cycle, if_pc=0x100 two cycles after.
REQ-029 SHALL cover: RESET_PC=32'hFFFF_FFF8 -> if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-030 SHALL cover: rst_n=0 asserted with full FIFO and redirect_valid=1 -> next cycle count=0, PC=RESET_PC, if_valid=0.
REQ-031 SHALL cover, with IFETCH_PERF_EN: 10 handshakes plus 2 redirects -> perf_fetch_cnt=10, perf_redirect_cnt=2.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC register feeding a 2-entry {pc, inst} fetch buffer toward decode.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] irom_adr,
    input  logic [31:0] irom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    logic [31:0] pc_r;
    logic [31:0] fifo_pc_r   [2];
    logic [31:0] fifo_inst_r [2];
    logic [1:0]  count_r;
    logic        head_r;
    logic        tail_r;
    logic        pop_s;
    logic        push_s;
    logic        redirect_lsb_unused_s;

    // Redirect targets are word aligned, so the low address bits are ignored.
    assign redirect_lsb_unused_s = ^redirect_pc[1:0];
    assign irom_adr              = pc_r;
    assign if_pc                 = fifo_pc_r[head_r];
    assign if_inst               = fifo_inst_r[head_r];

    // Handshake decode; valid is also masked while reset is asserted.
    always_comb begin
        if_valid = rst_n & (count_r != 2'd0) & ~redirect_valid;
        pop_s    = if_valid & if_ready;
        push_s   = ~redirect_valid & ((count_r < 2'd2) | pop_s);
    end

    // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            count_r <= 2'd0;
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
        end else if (redirect_valid) begin
            pc_r    <= {redirect_pc[31:2], 2'b00};
            count_r <= 2'd0;
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
        end else begin
            if (push_s) begin
                pc_r   <= pc_r + 32'd4;
                tail_r <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid && push_s) begin
            fifo_pc_r[tail_r]   <= pc_r;
            fifo_inst_r[tail_r] <= irom_inst;
        end
    end

`ifdef IFETCH_PERF_EN
    // Handshake and redirect event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_cnt    <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic
// compared against a queue-based reference model of the fetch buffer.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic [31:0] irom_adr, irom_inst, if_pc, if_inst;
    logic        if_valid;

    // ROM holds word index i at address 4*i.
    assign irom_inst = irom_adr >> 2;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_redirect_cnt;
    logic [31:0] w_pf, w_pr;
`endif

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n), .irom_adr(irom_adr), .irom_inst(irom_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    logic        w_rst_n;
    logic [31:0] w_adr, w_rom, w_pc, w_inst;
    logic        w_valid;
    assign w_rom = w_adr >> 2;

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .irom_adr(w_adr), .irom_inst(w_rom),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .if_valid(w_valid), .if_pc(w_pc), .if_inst(w_inst), .if_ready(1'b1)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(w_pf), .perf_redirect_cnt(w_pr)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    int          errors = 0;
    int          checks = 0;
    entry_t      mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_fetch, m_redir;
    bit          m_known = 1'b0;
    logic        s_valid;
    logic [31:0] s_pc, s_inst, s_adr, s_pf, s_pr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare with the model, then advance the model.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        logic ev;
        logic pop;
        int   n;
        @(negedge clk);
        rst_n = r; redirect_valid = rv; redirect_pc = rp; if_ready = rdy;
        #1;
        s_valid = if_valid; s_pc = if_pc; s_inst = if_inst; s_adr = irom_adr;
`ifdef IFETCH_PERF_EN
        s_pf = perf_fetch_cnt; s_pr = perf_redirect_cnt;
`else
        s_pf = 32'd0; s_pr = 32'd0;
`endif
        ev  = r && (mq.size() != 0) && !rv;
        pop = ev && rdy;
        if (m_known) begin
            check_eq("model_valid", {31'd0, s_valid}, {31'd0, ev});
            check_eq("model_adr", s_adr, m_pc);
            if (ev) begin
                check_eq("model_pc", s_pc, mq[0].pc);
                check_eq("model_inst", s_inst, mq[0].inst);
            end
`ifdef IFETCH_PERF_EN
            check_eq("model_perf_fetch", s_pf, m_fetch);
            check_eq("model_perf_redir", s_pr, m_redir);
`endif
        end
        @(posedge clk);
        if (!r) begin
            m_pc = 32'h0000_0000; mq.delete(); m_fetch = 32'd0; m_redir = 32'd0; m_known = 1'b1;
        end else if (rv) begin
            mq.delete(); m_pc = {rp[31:2], 2'b00}; m_redir = m_redir + 32'd1;
        end else begin
            n = mq.size();
            if (pop) begin
                void'(mq.pop_front());
                m_fetch = m_fetch + 32'd1;
            end
            if (n < 2 || pop) begin
                mq.push_back('{m_pc, m_pc >> 2});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] wrap_exp [3];
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ready = 1'b0;
        w_rst_n = 1'b0;

        // Reset release with decode always ready, then a 5-cycle stall from cycle 3.
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        check_eq("reset_valid", {31'd0, s_valid}, 32'd0);
        check_eq("reset_adr", s_adr, 32'd0);
        for (int c = 0; c <= 10; c++) begin
            cycle(1'b1, 1'b0, 32'd0, (c >= 3 && c <= 7) ? 1'b0 : 1'b1);
            if (c == 0) check_eq("first_cycle_valid", {31'd0, s_valid}, 32'd0);
            if (c == 1 || c == 2) begin
                check_eq("stream_pc", s_pc, 32'(4 * (c - 1)));
                check_eq("stream_inst", s_inst, 32'(c - 1));
            end
            if (c >= 5 && c <= 7) check_eq("stall_adr_frozen", s_adr, 32'h10);
            if (c >= 8) check_eq("resume_pc", s_pc, 32'(8 + 4 * (c - 8)));
        end

        // Redirect while full.
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        check_eq("redir_valid_c0", {31'd0, s_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("redir_valid_c1", {31'd0, s_valid}, 32'd0);
        check_eq("redir_adr_c1", s_adr, 32'h100);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("redir_valid_c2", {31'd0, s_valid}, 32'd1);
        check_eq("redir_pc_c2", s_pc, 32'h100);
        check_eq("redir_inst_c2", s_inst, 32'h40);

        // Reset with full buffer and a simultaneous redirect.
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        check_eq("rst_over_redir_valid", {31'd0, s_valid}, 32'd0);
        check_eq("rst_over_redir_adr", s_adr, 32'd0);

`ifdef IFETCH_PERF_EN
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        for (int c = 0; c <= 10; c++) cycle(1'b1, 1'b0, 32'd0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0040, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0080, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        check_eq("perf_fetch_10", s_pf, 32'd10);
        check_eq("perf_redirect_2", s_pr, 32'd2);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(63) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
                  32'($urandom),
                  1'($urandom_range(1)));
        end

        // PC wrap on the second instance.
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
        @(negedge clk); w_rst_n = 1'b1; #1;
        check_eq("wrap_first_valid", {31'd0, w_valid}, 32'd0);
        check_eq("wrap_reset_adr", w_adr, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_eq("wrap_valid", {31'd0, w_valid}, 32'd1);
            check_eq("wrap_pc", w_pc, wrap_exp[i]);
            check_eq("wrap_inst", w_inst, wrap_exp[i] >> 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
